// File: rtl/vliw_hazard_scoreboard_if.sv
// ID-stage bundle, flush and hazard/forwarding outputs of the 2-slot VLIW scoreboard.
// The decoder side uses master; the scoreboard uses slave.
interface vliw_hazard_scoreboard_if #(
    parameter int unsigned REG_AW = 3,
    parameter int unsigned CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_alu_rn;
    logic [REG_AW-1:0] id_alu_rm;
    logic              id_alu_rm_used;
    logic [REG_AW-1:0] id_alu_rd;
    logic              id_alu_regWrite;
    logic [REG_AW-1:0] id_mem_rn;
    logic [REG_AW-1:0] id_mem_rd;
    logic              id_mem_regWrite;
    logic              id_mem_store;
    logic              flush;

    logic              PCWrite_HU;
    logic              p1_regWrite_HU;
    logic              p2_stall;
    logic [1:0]        fA;
    logic [1:0]        fB;
    logic [1:0]        fC;
    logic [1:0]        fD;
    logic              fE;
    logic [CNT_W-1:0]  stall_cycles;

    modport master (
        output id_valid, id_alu_rn, id_alu_rm, id_alu_rm_used, id_alu_rd, id_alu_regWrite,
               id_mem_rn, id_mem_rd, id_mem_regWrite, id_mem_store, flush,
        input  PCWrite_HU, p1_regWrite_HU, p2_stall, fA, fB, fC, fD, fE, stall_cycles
    );

    modport slave (
        input  id_valid, id_alu_rn, id_alu_rm, id_alu_rm_used, id_alu_rd, id_alu_regWrite,
               id_mem_rn, id_mem_rd, id_mem_regWrite, id_mem_store, flush,
        output PCWrite_HU, p1_regWrite_HU, p2_stall, fA, fB, fC, fD, fE, stall_cycles
    );
endinterface

// File: rtl/vliw_hazard_scoreboard.sv
// Hazard detection and forwarding-select unit for the ALU+MEM slot VLIW pipeline.
// Tracks in-flight destinations in a shadow pipeline and registers EX-aligned selects.
module vliw_hazard_scoreboard #(
    parameter int unsigned REG_AW = 3,
    parameter int unsigned FWD_EN = 1,
    parameter int unsigned CNT_W  = 16
) (
    input logic                    clk,
    input logic                    reset,
    vliw_hazard_scoreboard_if.slave bus
);

    typedef struct packed {
        logic [REG_AW-1:0] alu_rd;
        logic              alu_we;
        logic [REG_AW-1:0] mem_rd;
        logic              mem_we;
    } shadow_t;

    localparam shadow_t Bubble = '0;

    // WB needs no tracking: the register file is write-first, so code 0 covers it.
    shadow_t ex_q, ex_d, mem_q, mem_d;
    logic [1:0] fa_q, fa_d, fb_q, fb_d, fc_q, fc_d, fd_q, fd_d;
    logic fe_ex_q, fe_ex_d, fe_q, fe_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic stall;

    function automatic logic hit(input logic [REG_AW-1:0] src, input logic used,
                                 input logic [REG_AW-1:0] rd, input logic we);
        return used && we && (src != '0) && (src == rd);
    endfunction

    // Youngest producer first; load beats ALU at equal age.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src, input logic used,
                                           input shadow_t ex, input shadow_t mem);
        if (hit(src, used, ex.alu_rd, ex.alu_we))        return 2'd1;
        else if (hit(src, used, mem.mem_rd, mem.mem_we)) return 2'd3;
        else if (hit(src, used, mem.alu_rd, mem.alu_we)) return 2'd2;
        else                                             return 2'd0;
    endfunction

    function automatic logic any_hit(input logic [REG_AW-1:0] src, input logic used,
                                     input shadow_t s);
        return hit(src, used, s.alu_rd, s.alu_we) || hit(src, used, s.mem_rd, s.mem_we);
    endfunction

    logic rn_used, rm_used, mrn_used, mrd_used;
    logic load_use, interlock, load_ex;

    always_comb begin
        rn_used  = 1'b1;
        rm_used  = bus.id_alu_rm_used;
        mrn_used = bus.id_mem_store || bus.id_mem_regWrite;
        mrd_used = bus.id_mem_store;

        load_use = hit(bus.id_alu_rn, rn_used,  ex_q.mem_rd, ex_q.mem_we)
                || hit(bus.id_alu_rm, rm_used,  ex_q.mem_rd, ex_q.mem_we)
                || hit(bus.id_mem_rn, mrn_used, ex_q.mem_rd, ex_q.mem_we);

        interlock = any_hit(bus.id_alu_rn, rn_used,  ex_q) || any_hit(bus.id_alu_rn, rn_used,  mem_q)
                 || any_hit(bus.id_alu_rm, rm_used,  ex_q) || any_hit(bus.id_alu_rm, rm_used,  mem_q)
                 || any_hit(bus.id_mem_rn, mrn_used, ex_q) || any_hit(bus.id_mem_rn, mrn_used, mem_q)
                 || any_hit(bus.id_mem_rd, mrd_used, ex_q) || any_hit(bus.id_mem_rd, mrd_used, mem_q);

        // Flush overrides any stall condition.
        stall = bus.id_valid && !bus.flush && ((FWD_EN != 0) ? load_use : interlock);

        load_ex = bus.id_valid && !bus.flush && !stall;

        mem_d = ex_q;
        ex_d  = Bubble;
        if (load_ex) begin
            ex_d.alu_rd = bus.id_alu_rd;
            ex_d.alu_we = bus.id_alu_regWrite && (bus.id_alu_rd != '0);
            ex_d.mem_rd = bus.id_mem_rd;
            ex_d.mem_we = bus.id_mem_regWrite && (bus.id_mem_rd != '0);
        end

        fa_d    = 2'd0;
        fb_d    = 2'd0;
        fc_d    = 2'd0;
        fd_d    = 2'd0;
        fe_ex_d = 1'b0;
        if ((FWD_EN != 0) && load_ex) begin
            fa_d    = fwd_sel(bus.id_alu_rn, rn_used,  ex_q, mem_q);
            fb_d    = fwd_sel(bus.id_alu_rm, rm_used,  ex_q, mem_q);
            fc_d    = fwd_sel(bus.id_mem_rn, mrn_used, ex_q, mem_q);
            fd_d    = fwd_sel(bus.id_mem_rd, mrd_used, ex_q, mem_q);
            fe_ex_d = hit(bus.id_mem_rd, mrd_used, ex_q.mem_rd, ex_q.mem_we);
        end
        fe_d = fe_ex_q;

        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q    <= Bubble;
            mem_q   <= Bubble;
            fa_q    <= 2'd0;
            fb_q    <= 2'd0;
            fc_q    <= 2'd0;
            fd_q    <= 2'd0;
            fe_ex_q <= 1'b0;
            fe_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            fc_q    <= fc_d;
            fd_q    <= fd_d;
            fe_ex_q <= fe_ex_d;
            fe_q    <= fe_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        bus.PCWrite_HU     = !stall;
        bus.p1_regWrite_HU = !stall;
        bus.p2_stall       = stall;
        bus.fA             = fa_q;
        bus.fB             = fb_q;
        bus.fC             = fc_q;
        bus.fD             = fd_q;
        bus.fE             = fe_q;
        bus.stall_cycles   = cnt_q;
    end

endmodule
